// File: rtl/debounce_edge_if.sv
// Bus between a raw switch input and its debounced level, strobes and edge count.
interface debounce_edge_if #(
    parameter int EVT_W = 8
);
    logic             din;
    logic             q_level;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             busy;
    logic [EVT_W-1:0] rise_count;

    modport master (
        output din,
        input  q_level, rise_pulse, fall_pulse, busy, rise_count
    );

    modport slave (
        input  din,
        output q_level, rise_pulse, fall_pulse, busy, rise_count
    );
endinterface

// File: rtl/debounce_edge.sv
// Switch conditioner: 2-FF synchronizer, stability counter, registered level,
// one-cycle rise/fall strobes and a wrapping count of accepted rising edges.
module debounce_edge #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4,
    parameter int EVT_W      = 8
) (
    input  logic           clk,
    input  logic           reset,
    debounce_edge_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    assign bus.busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            cnt            <= '0;
            bus.q_level    <= 1'b0;
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            bus.rise_count <= '0;
        end else begin
            sync1          <= bus.din;
            sync2          <= sync1;
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            // Any return to the current level aborts a pending change.
            if (sync2 == bus.q_level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt            <= '0;
                bus.q_level    <= sync2;
                bus.rise_pulse <= sync2;
                bus.fall_pulse <= ~sync2;
                if (sync2)
                    bus.rise_count <= bus.rise_count + EVT_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: cycle table for reset/rise/fall/bounce,
// then hand-written sequences for toggling, mid-count reset and count wrap.
module tb_debounce_edge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    debounce_edge_if #(.EVT_W(8)) bus ();

    debounce_edge #(.STABLE_CNT(4), .CNT_W(4), .EVT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #15 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       din;
        logic       q;
        logic       rp;
        logic       fp;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, return 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic d);
        @(negedge clk);
        reset  = r;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_rise;
        int n_fall;
        bus.din = 1'b0;

        // Scenario 1: reset with din=1, then rise accepted 5 edges after E0
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        // Scenario 3: din falls and holds
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        // Scenario 2: two-cycle bounce from q_level=0
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst, tbl[i].din);
            chk($sformatf("v%0d q_level", i),    32'(bus.q_level),    32'(tbl[i].q));
            chk($sformatf("v%0d rise_pulse", i), 32'(bus.rise_pulse), 32'(tbl[i].rp));
            chk($sformatf("v%0d fall_pulse", i), 32'(bus.fall_pulse), 32'(tbl[i].fp));
            chk($sformatf("v%0d busy", i),       32'(bus.busy),       32'(tbl[i].busy));
            chk($sformatf("v%0d rise_count", i), 32'(bus.rise_count), 32'(tbl[i].cnt));
        end

        // Scenario 4: 3-cycle half-period toggling never gets through
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'(((i / 3) % 2) == 0));
            chk("toggle q_level", 32'(bus.q_level), 32'd0);
            chk("toggle pulses", 32'({bus.rise_pulse, bus.fall_pulse}), 32'd0);
        end
        n_rise = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1);
            if (bus.rise_pulse) n_rise++;
        end
        chk("hold rise pulses", 32'(n_rise), 32'd1);
        chk("hold q_level", 32'(bus.q_level), 32'd1);
        chk("hold rise_count", 32'(bus.rise_count), 32'd2);

        // Scenario 5: back to 0, then reset while a rise is pending at counter=2
        n_fall = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            if (bus.fall_pulse) n_fall++;
        end
        chk("drop fall pulses", 32'(n_fall), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("pending busy", 32'(bus.busy), 32'd1);
        step(1'b1, 1'b1);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset q_level", 32'(bus.q_level), 32'd0);
        chk("midreset pulses", 32'({bus.rise_pulse, bus.fall_pulse}), 32'd0);
        chk("midreset rise_count", 32'(bus.rise_count), 32'd0);
        step(1'b0, 1'b1);
        chk("postreset q_level", 32'(bus.q_level), 32'd0);
        chk("postreset pulses", 32'({bus.rise_pulse, bus.fall_pulse}), 32'd0);

        // Scenario 6: 256 clean rises wrap the 8-bit count back to 0
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 7; k++) step(1'b0, 1'b1);
            chk($sformatf("wrap q_level %0d", i), 32'(bus.q_level), 32'd1);
            chk($sformatf("wrap rise_count %0d", i), 32'(bus.rise_count), 32'((i + 1) % 256));
            for (int k = 0; k < 7; k++) step(1'b0, 1'b0);
        end
        chk("final rise_count", 32'(bus.rise_count), 32'd0);
        chk("final q_level", 32'(bus.q_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
